// File: rtl/multi_channel_modulation_pkg.sv
// Shared types and defaults for the multi-channel modulation block.
// Holds the mode enum, default widths and the per-mode output gate function.
package modulation_pkg;

  typedef enum logic [1:0] {
    SQUARE    = 2'd0,
    PULSE     = 2'd1,
    HOLD_HIGH = 2'd2,
    HOLD_LOW  = 2'd3
  } mod_mode_e;

  localparam int CNT_W_DEF      = 8;
  localparam int DEFAULT_HP_DEF = 20;

  function automatic logic gate_of(
    input mod_mode_e m,
    input logic      ph,
    input logic      cnt_zero
  );
    logic r;
    r = 1'b0;
    unique case (m)
      SQUARE:    r = ph;
      PULSE:     r = ph & cnt_zero;
      HOLD_HIGH: r = 1'b1;
      HOLD_LOW:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multi_channel_modulation_mod_channel.sv
// One modulation channel: half-period counter, phase bit, pending config.
// Ports: clk/rst, sync_edge, resync, enable, wr + cfg fields, gate (registered).
module mod_channel
  import modulation_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEFAULT_HP = DEFAULT_HP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_edge,
  input  logic             resync,
  input  logic             enable,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_hp,
  input  logic [CNT_W-1:0] wr_phase,
  input  mod_mode_e        wr_mode,
  output logic             gate
);

  logic [CNT_W-1:0] hp, phase, cnt;
  logic [CNT_W-1:0] p_hp, p_phase;
  mod_mode_e        mode, p_mode;
  logic             pv, ph;

  logic [CNT_W-1:0] hp_n, phase_n, cnt_n;
  logic [CNT_W-1:0] hp_eff, hp_eff_n;
  logic [CNT_W:0]   cnt_inc;
  mod_mode_e        mode_n;
  logic             ph_n, apply;

  always_comb begin
    hp_eff  = (hp == '0) ? CNT_W'(1) : hp;
    cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
    cnt_n   = cnt;
    ph_n    = ph;
    apply   = resync;
    if (!resync) begin
      if (sync_edge) begin
        if (cnt_inc < {1'b0, hp_eff}) begin
          cnt_n = cnt_inc[CNT_W-1:0];
        end else begin
          cnt_n = '0;
          ph_n  = ~ph;
          // full-period boundary is the 0->1 toggle
          apply = ~ph;
        end
      end
      if (!enable) apply = 1'b1;
    end
    hp_n    = hp;
    phase_n = phase;
    mode_n  = mode;
    if (apply && pv) begin
      hp_n    = p_hp;
      phase_n = p_phase;
      mode_n  = p_mode;
    end
    hp_eff_n = (hp_n == '0) ? CNT_W'(1) : hp_n;
    if (resync) begin
      cnt_n = (phase_n < hp_eff_n) ? phase_n : hp_eff_n - CNT_W'(1);
      ph_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp      <= CNT_W'(DEFAULT_HP);
      phase   <= '0;
      mode    <= SQUARE;
      p_hp    <= '0;
      p_phase <= '0;
      p_mode  <= SQUARE;
      pv      <= 1'b0;
      cnt     <= '0;
      ph      <= 1'b1;
      gate    <= 1'b1;
    end else begin
      hp    <= hp_n;
      phase <= phase_n;
      mode  <= mode_n;
      cnt   <= cnt_n;
      ph    <= ph_n;
      // a write in the apply cycle survives as the new pending value
      if (wr) begin
        p_hp    <= wr_hp;
        p_phase <= wr_phase;
        p_mode  <= wr_mode;
        pv      <= 1'b1;
      end else if (apply) begin
        pv <= 1'b0;
      end
      gate <= ~enable | gate_of(mode_n, ph_n, cnt_n == '0);
    end
  end

endmodule

// File: rtl/multi_channel_modulation.sv
// Top: sync edge detect, sync_tick, cfg decode, NUM_CH mod_channel instances.
// Ports: clk, rst, sync, resync, mod_enable, cfg_*, mod_out, sync_tick.
module multi_channel_modulation
  import modulation_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEFAULT_HP = DEFAULT_HP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              resync,
  input  logic [NUM_CH-1:0] mod_enable,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half_period,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic [1:0]        cfg_mode,
  output logic [NUM_CH-1:0] mod_out,
  output logic              sync_tick
);

  logic sync_q, sync_edge;
  logic [NUM_CH-1:0] wr;

  // sync_q resets high so a high sync at release is not an edge
  assign sync_edge = sync & ~sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 1'b1;
      sync_tick <= 1'b0;
    end else begin
      sync_q    <= sync;
      sync_tick <= sync_edge;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = cfg_wr && (cfg_ch == 4'(i));

    mod_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_HP (DEFAULT_HP)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .sync_edge (sync_edge),
      .resync    (resync),
      .enable    (mod_enable[i]),
      .wr        (wr[i]),
      .wr_hp     (cfg_half_period),
      .wr_phase  (cfg_phase),
      .wr_mode   (mod_mode_e'(cfg_mode)),
      .gate      (mod_out[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_modulation.sv
// Self-checking bench for multi_channel_modulation.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_multi_channel_modulation;
  import modulation_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int DHP    = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sync = 1'b1;
  logic              resync = 1'b0;
  logic [NUM_CH-1:0] mod_enable = '1;
  logic              cfg_wr = 1'b0;
  logic [3:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_half_period = '0;
  logic [CNT_W-1:0]  cfg_phase = '0;
  logic [1:0]        cfg_mode = '0;
  logic [NUM_CH-1:0] mod_out;
  logic              sync_tick;

  multi_channel_modulation #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_HP (DHP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sync            (sync),
    .resync          (resync),
    .mod_enable      (mod_enable),
    .cfg_wr          (cfg_wr),
    .cfg_ch          (cfg_ch),
    .cfg_half_period (cfg_half_period),
    .cfg_phase       (cfg_phase),
    .cfg_mode        (cfg_mode),
    .mod_out         (mod_out),
    .sync_tick       (sync_tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int gcyc    = 0;
  int k_edges = 0;
  bit auto_sync = 1'b1;

  // behavioural model state
  int m_hp[NUM_CH], m_phs[NUM_CH], m_mode[NUM_CH];
  int m_cnt[NUM_CH], m_ph[NUM_CH];
  int p_hp[NUM_CH], p_phs[NUM_CH], p_mode[NUM_CH];
  bit m_pv[NUM_CH];
  bit m_sq, m_tick;
  logic [NUM_CH-1:0] m_out;

  task automatic model_clock();
    bit e, ap;
    int h;
    e = sync && !m_sq;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cnt[i] = 0; m_ph[i] = 1; m_mode[i] = 0;
        m_hp[i] = DHP; m_phs[i] = 0; m_pv[i] = 0;
      end
      m_out = '1; m_tick = 0; m_sq = 1;
    end else begin
      m_tick = e;
      m_sq = sync;
      for (int i = 0; i < NUM_CH; i++) begin
        ap = resync;
        h = (m_hp[i] < 1) ? 1 : m_hp[i];
        if (!resync && e) begin
          if (m_cnt[i] + 1 < h) m_cnt[i]++;
          else begin
            m_cnt[i] = 0;
            m_ph[i] = 1 - m_ph[i];
            if (m_ph[i] == 1) ap = 1;
          end
        end
        if (!mod_enable[i]) ap = 1;
        if (ap && m_pv[i]) begin
          m_hp[i] = p_hp[i]; m_phs[i] = p_phs[i];
          m_mode[i] = p_mode[i]; m_pv[i] = 0;
        end
        if (resync) begin
          h = (m_hp[i] < 1) ? 1 : m_hp[i];
          m_cnt[i] = (m_phs[i] < h) ? m_phs[i] : h - 1;
          m_ph[i] = 1;
        end
        if (cfg_wr && cfg_ch == i) begin
          p_hp[i] = cfg_half_period; p_phs[i] = cfg_phase;
          p_mode[i] = cfg_mode; m_pv[i] = 1;
        end
        if (!mod_enable[i]) m_out[i] = 1'b1;
        else case (m_mode[i])
          0: m_out[i] = (m_ph[i] == 1);
          1: m_out[i] = (m_ph[i] == 1) && (m_cnt[i] == 0);
          2: m_out[i] = 1'b1;
          default: m_out[i] = 1'b0;
        endcase
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_clock();
    if (m_tick) k_edges++;
    @(negedge clk);
    gcyc++;
    resync = 1'b0;
    cfg_wr = 1'b0;
    if (auto_sync) sync = (gcyc % 10) < 5;
  endtask

  task automatic run(input int n);
    repeat (n) tick_clk();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    mod_enable = '1;
    k_edges = 0;
  endtask

  task automatic cfg(input int ch, input int hp, input int phs, input int md);
    cfg_wr = 1'b1;
    cfg_ch = 4'(ch);
    cfg_half_period = CNT_W'(hp);
    cfg_phase = CNT_W'(phs);
    cfg_mode = 2'(md);
    tick_clk();
  endtask

  task automatic test_reset();
    auto_sync = 1'b0;
    rst = 1'b1; sync = 1'b1; resync = 1'b1; cfg_wr = 1'b1;
    cfg_ch = 4'd0; cfg_half_period = 8'd1;
    tick_clk();
    rst = 1'b1;
    run(2);
    n_tests++;
    if (mod_out !== 4'hF) begin
      n_fail++; $display("FAIL reset_out got=%h exp=%h", mod_out, 4'hF);
    end
    n_tests++;
    if (sync_tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_tick got=%b exp=0", sync_tick);
    end
    rst = 1'b0; sync = 1'b1;
    tick_clk();
    n_tests++;
    if (sync_tick !== 1'b0) begin
      n_fail++; $display("FAIL release_high_tick got=%b exp=0", sync_tick);
    end
    sync = 1'b0; tick_clk();
    sync = 1'b1; tick_clk();
    n_tests++;
    if (sync_tick !== 1'b1) begin
      n_fail++; $display("FAIL first_edge_tick got=%b exp=1", sync_tick);
    end
    tick_clk();
    n_tests++;
    if (sync_tick !== 1'b0) begin
      n_fail++; $display("FAIL tick_width got=%b exp=0", sync_tick);
    end
    auto_sync = 1'b1;
  endtask

  task automatic test_square();
    logic e0;
    do_reset();
    repeat (450) begin
      tick_clk();
      if (m_tick) begin
        e0 = ((k_edges / 20) % 2) == 0;
        n_tests++;
        if (mod_out[0] !== e0) begin
          n_fail++;
          $display("FAIL square_ch0 edge=%0d got=%b exp=%b", k_edges, mod_out[0], e0);
        end
        n_tests++;
        if (mod_out !== m_out || sync_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL square_all got=%h/%b exp=%h/1", mod_out, sync_tick, m_out);
        end
      end
    end
    n_tests++;
    if (k_edges < 40) begin
      n_fail++; $display("FAIL square_edges got=%0d exp>=40", k_edges);
    end
  endtask

  task automatic test_pulse();
    logic e1;
    int guard;
    do_reset();
    guard = 0;
    while (k_edges < 5 && guard < 200) begin tick_clk(); guard++; end
    cfg(1, 3, 0, PULSE);
    repeat (600) begin
      tick_clk();
      if (m_tick && k_edges <= 58) begin
        if (k_edges < 20) e1 = 1'b1;
        else if (k_edges < 40) e1 = 1'b0;
        else e1 = ((k_edges - 40) % 6) == 0;
        n_tests++;
        if (mod_out[1] !== e1 || mod_out !== m_out) begin
          n_fail++;
          $display("FAIL pulse_ch1 edge=%0d got=%h exp_b1=%b model=%h",
                   k_edges, mod_out, e1, m_out);
        end
      end
    end
    n_tests++;
    if (k_edges < 58) begin
      n_fail++; $display("FAIL pulse_edges got=%0d exp>=58", k_edges);
    end
  endtask

  task automatic test_resync();
    logic e2;
    int guard;
    do_reset();
    cfg(2, 8, 5, SQUARE);
    guard = 0;
    while (!(sync && (gcyc % 10) == 0) && guard < 40) begin
      tick_clk(); guard++;
    end
    resync = 1'b1;
    tick_clk();
    n_tests++;
    if (mod_out[2] !== 1'b1 || m_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_edge got=%b exp=1 edge_seen=%b", mod_out[2], m_tick);
    end
    k_edges = 0;
    repeat (125) begin
      tick_clk();
      if (m_tick) begin
        e2 = (k_edges < 3) || (k_edges >= 11);
        n_tests++;
        if (mod_out[2] !== e2 || mod_out !== m_out) begin
          n_fail++;
          $display("FAIL resync_ch2 edge=%0d got=%h exp_b2=%b", k_edges, mod_out, e2);
        end
      end
    end
  endtask

  task automatic test_hp0_badch();
    logic e0;
    do_reset();
    cfg(7, 1, 0, HOLD_LOW);
    resync = 1'b1;
    tick_clk();
    k_edges = 0;
    repeat (195) begin
      tick_clk();
      if (m_tick && k_edges < 20) begin
        n_tests++;
        if (mod_out !== 4'hF) begin
          n_fail++;
          $display("FAIL bad_ch edge=%0d got=%h exp=F", k_edges, mod_out);
        end
      end
    end
    cfg(0, 0, 0, SQUARE);
    resync = 1'b1;
    tick_clk();
    k_edges = 0;
    repeat (100) begin
      tick_clk();
      if (m_tick) begin
        e0 = (k_edges % 2) == 0;
        n_tests++;
        if (mod_out[0] !== e0) begin
          n_fail++;
          $display("FAIL hp0_ch0 edge=%0d got=%b exp=%b", k_edges, mod_out[0], e0);
        end
      end
    end
  endtask

  task automatic test_enable_rst();
    do_reset();
    cfg(3, 20, 0, HOLD_LOW);
    mod_enable[3] = 1'b0;
    tick_clk();
    n_tests++;
    if (mod_out[3] !== 1'b1) begin
      n_fail++; $display("FAIL dis_ch3 got=%b exp=1", mod_out[3]);
    end
    mod_enable[3] = 1'b1;
    tick_clk();
    n_tests++;
    if (mod_out[3] !== 1'b0) begin
      n_fail++; $display("FAIL reen_ch3 got=%b exp=0", mod_out[3]);
    end
    mod_enable[3] = 1'b0;
    tick_clk();
    n_tests++;
    if (mod_out[3] !== 1'b1) begin
      n_fail++; $display("FAIL dis2_ch3 got=%b exp=1", mod_out[3]);
    end
    mod_enable[3] = 1'b1;
    run(35);
    n_tests++;
    if (mod_out !== 4'h7) begin
      n_fail++; $display("FAIL hold_low_run got=%h exp=7", mod_out);
    end
    cfg(0, 2, 0, SQUARE);
    run(3);
    rst = 1'b1; cfg_wr = 1'b1; cfg_ch = 4'd1;
    cfg_half_period = 8'd1; cfg_mode = 2'(HOLD_LOW);
    tick_clk();
    rst = 1'b0;
    n_tests++;
    if (mod_out !== 4'hF || sync_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_rst got=%h/%b exp=F/0", mod_out, sync_tick);
    end
    resync = 1'b1;
    tick_clk();
    k_edges = 0;
    repeat (195) begin
      tick_clk();
      if (m_tick && k_edges < 20) begin
        n_tests++;
        if (mod_out !== 4'hF) begin
          n_fail++;
          $display("FAIL pend_lost edge=%0d got=%h exp=F", k_edges, mod_out);
        end
      end
    end
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    auto_sync = 1'b0;
    do_reset();
    repeat (4000) begin
      if ($urandom_range(0, 2) == 0) sync = ~sync;
      rst = ($urandom_range(0, 599) == 0);
      resync = ($urandom_range(0, 60) == 0);
      cfg_wr = ($urandom_range(0, 6) == 0);
      cfg_ch = 4'($urandom_range(0, 7));
      cfg_half_period = 8'($urandom_range(0, 5));
      cfg_phase = 8'($urandom_range(0, 7));
      cfg_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0)
        mod_enable[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
      tick_clk();
      n_tests++;
      if (mod_out !== m_out) begin
        n_fail++;
        if (shown < 10) $display("FAIL rand_out cyc=%0d got=%h exp=%h", gcyc, mod_out, m_out);
        shown++;
      end
      n_tests++;
      if (sync_tick !== m_tick) begin
        n_fail++;
        if (shown < 10) $display("FAIL rand_tick cyc=%0d got=%b exp=%b", gcyc, sync_tick, m_tick);
        shown++;
      end
    end
    rst = 1'b0;
    auto_sync = 1'b1;
  endtask

  initial begin
    test_reset();
    test_square();
    test_pulse();
    test_resync();
    test_hp0_badch();
    test_enable_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_modulation.md
MULTI_CHANNEL_MODULATION -- requirements
Module: multi_channel_modulation

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent modulation channels (1..16).
REQ-002 Parameter CNT_W, default 8, width of half-period and phase fields.
REQ-003 Parameter DEFAULT_HP, default 20, half-period loaded into every channel at reset.
REQ-004 clk  in  1  single clock; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 sync  in  1  carrier sync, level; its rising edge is the modulation time base.
REQ-007 resync  in  1  one-cycle pulse; realigns all channels to their phase offsets.
REQ-008 mod_enable  in  NUM_CH  per-channel enable; a disabled channel drives 1.
REQ-009 cfg_wr  in  1  configuration write strobe.
REQ-010 cfg_ch  in  4  channel index for cfg_wr.
REQ-011 cfg_half_period  in  CNT_W  half-period in sync edges.
REQ-012 cfg_phase  in  CNT_W  counter preload applied on resync.
REQ-013 cfg_mode  in  2  mode, mod_mode_e: SQUARE=0, PULSE=1, HOLD_HIGH=2, HOLD_LOW=3.
REQ-014 mod_out  out  NUM_CH  modulation gate per channel, registered.
REQ-015 sync_tick  out  1  one-cycle pulse, one cycle after each detected sync rising edge.

Function
REQ-016 Sync edge: sync sampled into sync_q; edge = sync & !sync_q; sync_q resets to 1, so sync high at reset release gives no edge.
REQ-017 Each channel keeps active {half_period, phase, mode}, pending copy, pending_valid flag, counter cnt, state bit ph.
REQ-018 Effective half-period hp = max(half_period, 1); 0 behaves as 1.
REQ-019 On an edge, if cnt+1 < hp then cnt increments, else cnt <= 0 and ph toggles; compare at CNT_W+1 bits, no wrap.
REQ-020 SQUARE: mod_out = ph; period 2*hp sync edges, 50% duty.
REQ-021 PULSE: mod_out = 1 only while ph=1 and cnt=0 (one sync interval per 2*hp edges), else 0.
REQ-022 HOLD_HIGH: mod_out = 1; HOLD_LOW: mod_out = 0; counters keep running in both.
REQ-023 mod_out[i] = 1 whenever mod_enable[i] = 0, overriding mode, with no extra latency beyond the output register.
REQ-024 mod_out updates one cycle after the edge cycle that changes cnt/ph (same cycle as sync_tick).
REQ-025 cfg_wr with cfg_ch < NUM_CH writes pending and sets pending_valid; cfg_ch >= NUM_CH ignored.
REQ-026 Pending applies when ph toggles 0->1 (full-period boundary), when mod_enable[i] = 0 (next cycle), or on resync.
REQ-027 Apply copies the pending value registered before this cycle; a cfg_wr in the apply cycle stays pending.
REQ-028 resync: every channel applies pending if valid, cnt <= min(phase, hp-1), ph <= 1; an edge in the same cycle is ignored.
REQ-029 Active half-period changes take effect at the next edge; cnt >= new hp wraps on that edge per REQ-019.

Reset
REQ-030 On rst: cnt=0, ph=1, mode=SQUARE, half_period=DEFAULT_HP, phase=0, pending_valid=0, mod_out=all 1, sync_tick=0, sync_q=1.
REQ-031 rst mid-period discards pending config and in-flight counts; rst overrides resync and cfg_wr.

Structure
REQ-032 Package modulation_pkg holds mod_mode_e, CNT_W default and DEFAULT_HP default.
REQ-033 Per-channel logic in sub-module mod_channel, instantiated NUM_CH times; edge detect, sync_tick and cfg decode at top level.

Verification
REQ-034 Reset, hp=20, SQUARE, enable=1, edges every 10 clk -> mod_out[0] starts 1, toggles after every 20 edges.
REQ-035 cfg ch1 hp=3 mode=PULSE mid-period -> old hp kept until ph 0->1, then mod_out[1] high one interval per 6 edges.
REQ-036 cfg_phase ch2=5, hp=8, resync on an edge cycle -> edge ignored, ph=1, cnt=5, toggle after 3 more edges.
REQ-037 hp=0 written to ch0 -> ph toggles every edge; cfg_ch=7 (NUM_CH=4) -> no channel changes.
REQ-038 mod_enable[3]=0 during HOLD_LOW -> mod_out[3]=1; re-enable -> 0 one cycle later; rst mid-run -> all 1, pending lost.
